vga_ctrl: RTL and testbench

//  Raster timing generator and pixel fetch front-end for the VGA output path.

---
 rtl/vga_ctrl.sv | 166 ++++++++++++++++
 tb/tb_vga_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl.sv
// vga_ctrl: raster timing generator and pixel fetch front-end for the VGA path.
// Two free-running counters define the raster position. The active-area
// coordinate is decoded straight from them and sent to the renderers. The
// renderer data returns PIX_LAT clocks later and is blanked outside the active
// area. The sync signals travel down a matching delay line, so rgb, hsync and
// vsync all leave the output register aligned to the same pixel.
module vga_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter int PIX_LAT = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_VALID);

    // One slot of the delay line that tracks a pixel from request to output.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } pipe_t;

    localparam pipe_t PIPE_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic        frame_wrap;
    logic [15:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    pipe_t       stage_now;
    pipe_t       stage_out;

    // Next raster position: cnt_h wraps every line, cnt_v steps on each line wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_h_d    = cnt_h_q + 10'd1;
        cnt_v_d    = cnt_v_q;
        frame_wrap = 1'b0;
        if (cnt_h_q == H_LAST) begin
            cnt_h_d = '0;
            if (cnt_v_q == V_LAST) begin
                cnt_v_d    = '0;
                frame_wrap = 1'b1;
            end else begin
                cnt_v_d = cnt_v_q + 10'd1;
            end
        end
    end

    // Raster counters, the only timing state.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Decode the active-area request and coordinates from the current counters.
    always_comb begin
        pix_req = (cnt_h_q >= H_ACT_LO) && (cnt_h_q < H_ACT_HI) &&
                  (cnt_v_q >= V_ACT_LO) && (cnt_v_q < V_ACT_HI);
        pix_x   = pix_req ? (cnt_h_q - H_ACT_LO) : '0;
        pix_y   = pix_req ? (cnt_v_q - V_ACT_LO) : '0;
        stage_now.active = pix_req;
        stage_now.hs     = (cnt_h_q >= H_SYNC_W);
        stage_now.vs     = (cnt_v_q >= V_SYNC_W);
    end

    generate
        if (PIX_LAT == 0) begin : g_no_pipe
            assign stage_out = stage_now;
        end else begin : g_pipe
            pipe_t pipe_q [PIX_LAT];
            pipe_t pipe_d [PIX_LAT];

            // Shift {active,hs,vs} along by one slot per clock.
            always_comb begin
                pipe_d[0] = stage_now;
                for (int i = 1; i < PIX_LAT; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Delay line storage, flushed to the idle (blanked, sync inactive) pattern.
            always_ff @(posedge vga_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    // NOTE: this array is a handful of flops, not a RAM, so it takes a reset like any register.
                    for (int i = 0; i < PIX_LAT; i++) begin
                        pipe_q[i] <= PIPE_IDLE;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign stage_out = pipe_q[PIX_LAT-1];
        end
    endgenerate

    // Output stage next values: blank rgb outside the active area, and count frame wraps.
    always_comb begin
        rgb_d         = stage_out.active ? pix_data : 16'h0000;
        hsync_d       = stage_out.hs;
        vsync_d       = stage_out.vs;
        frame_start_d = frame_wrap;
        frame_cnt_d   = frame_wrap ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    end

    // Output registers feeding the DAC and the game timers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_q         <= 16'h0000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'h0000;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: directed bench for vga_ctrl.
// Three copies use a tiny 13x7 raster (PIX_LAT = 0, 1, 3), each fed by a
// renderer model that returns {pix_y[5:0], pix_x} after PIX_LAT clocks.
// A fourth copy uses the full 640x480 timing with pix_data tied to 16'hFFFF,
// and checks the line timing and the position of the first active pixel.
module tb_vga_ctrl;

    // Small raster: 13 clocks per line, 7 lines per frame, 91 clocks per frame.
    localparam int SH_SYNC = 3, SH_BACK = 2, SH_VALID = 6, SH_FRONT = 2;
    localparam int SV_SYNC = 2, SV_BACK = 1, SV_VALID = 3, SV_FRONT = 1;
    localparam int SH_TOTAL = 13;
    localparam int SV_TOTAL = 7;
    localparam int S_FRAME  = 91;
    localparam int SH_ACT   = 5;
    localparam int SV_ACT   = 3;

    // Full raster: first active pixel is at cnt_h = 144 on line 35.
    localparam int D_FIRST_REQ = 35 * 800 + 144;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0]  x0, y0, x1, y1, x3, y3, xd, yd;
    logic        req0, req1, req3, reqd;
    logic        hs0, hs1, hs3, hsd;
    logic        vs0, vs1, vs3, vsd;
    logic [15:0] rgb0, rgb1, rgb3, rgbd;
    logic        fs0, fs1, fs3, fsd;
    logic [15:0] fc0, fc1, fc3, fcd;
    logic [15:0] pd0, pd1, pd3, pdd;

    // Renderer models: coordinate-derived colour returned after PIX_LAT clocks.
    logic [15:0] r1_q;
    logic [15:0] r3_q [3];
    always @(posedge clk) begin
        r1_q    <= {y1[5:0], x1};
        r3_q[0] <= {y3[5:0], x3};
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end
    assign pd0 = {y0[5:0], x0};
    assign pd1 = r1_q;
    assign pd3 = r3_q[2];
    assign pdd = 16'hFFFF;

    vga_ctrl #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_VALID(SH_VALID), .H_FRONT(SH_FRONT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_VALID(SV_VALID), .V_FRONT(SV_FRONT),
        .PIX_LAT(0)
    ) u_l0 (
        .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd0),
        .pix_x(x0), .pix_y(y0), .pix_req(req0), .hsync(hs0), .vsync(vs0),
        .rgb(rgb0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_ctrl #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_VALID(SH_VALID), .H_FRONT(SH_FRONT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_VALID(SV_VALID), .V_FRONT(SV_FRONT),
        .PIX_LAT(1)
    ) u_l1 (
        .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd1),
        .pix_x(x1), .pix_y(y1), .pix_req(req1), .hsync(hs1), .vsync(vs1),
        .rgb(rgb1), .frame_start(fs1), .frame_cnt(fc1)
    );

    vga_ctrl #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_VALID(SH_VALID), .H_FRONT(SH_FRONT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_VALID(SV_VALID), .V_FRONT(SV_FRONT),
        .PIX_LAT(3)
    ) u_l3 (
        .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd3),
        .pix_x(x3), .pix_y(y3), .pix_req(req3), .hsync(hs3), .vsync(vs3),
        .rgb(rgb3), .frame_start(fs3), .frame_cnt(fc3)
    );

    vga_ctrl u_full (
        .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pdd),
        .pix_x(xd), .pix_y(yd), .pix_req(reqd), .hsync(hsd), .vsync(vsd),
        .rgb(rgbd), .frame_start(fsd), .frame_cnt(fcd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one small-raster instance against the reference raster, n clocks after reset release.
    task automatic check_small(input string name, input int lat, input int n,
                               input logic req, input logic [9:0] x, input logic [9:0] y,
                               input logic [15:0] rgb_o, input logic hs, input logic vs,
                               input logic fs, input logic [15:0] fc);
        int          h, v, hp, vp, p;
        logic        act, actp;
        logic [9:0]  ex, ey, xp, yp;
        logic [15:0] e_rgb;
        logic        e_hs, e_vs, e_fs;
        h   = n % SH_TOTAL;
        v   = (n / SH_TOTAL) % SV_TOTAL;
        act = (h >= SH_ACT) && (h < SH_ACT + SH_VALID) && (v >= SV_ACT) && (v < SV_ACT + SV_VALID);
        ex  = act ? 10'(h - SH_ACT) : 10'd0;
        ey  = act ? 10'(v - SV_ACT) : 10'd0;
        if (n < lat + 1) begin
            e_rgb = 16'h0000;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
        end else begin
            p     = n - lat - 1;
            hp    = p % SH_TOTAL;
            vp    = (p / SH_TOTAL) % SV_TOTAL;
            actp  = (hp >= SH_ACT) && (hp < SH_ACT + SH_VALID) &&
                    (vp >= SV_ACT) && (vp < SV_ACT + SV_VALID);
            xp    = 10'(hp - SH_ACT);
            yp    = 10'(vp - SV_ACT);
            e_rgb = actp ? {yp[5:0], xp} : 16'h0000;
            e_hs  = (hp >= SH_SYNC);
            e_vs  = (vp >= SV_SYNC);
        end
        e_fs = (n > 0) && (n % S_FRAME == 0);
        check($sformatf("%s.pix_req n=%0d", name, n), 32'(req), 32'(act));
        check($sformatf("%s.pix_x n=%0d", name, n), 32'(x), 32'(ex));
        check($sformatf("%s.pix_y n=%0d", name, n), 32'(y), 32'(ey));
        check($sformatf("%s.rgb n=%0d", name, n), 32'(rgb_o), 32'(e_rgb));
        check($sformatf("%s.hsync n=%0d", name, n), 32'(hs), 32'(e_hs));
        check($sformatf("%s.vsync n=%0d", name, n), 32'(vs), 32'(e_vs));
        check($sformatf("%s.frame_start n=%0d", name, n), 32'(fs), 32'(e_fs));
        check($sformatf("%s.frame_cnt n=%0d", name, n), 32'(fc), 32'(n / S_FRAME));
    endtask

    task automatic check_all_small(input int n);
        check_small("L0", 0, n, req0, x0, y0, rgb0, hs0, vs0, fs0, fc0);
        check_small("L1", 1, n, req1, x1, y1, rgb1, hs1, vs1, fs1, fc1);
        check_small("L3", 3, n, req3, x3, y3, rgb3, hs3, vs3, fs3, fc3);
    endtask

    task automatic check_full_reset(input string tag);
        check({tag, ".full.rgb"}, 32'(rgbd), 32'h0);
        check({tag, ".full.hsync"}, 32'(hsd), 32'h1);
        check({tag, ".full.vsync"}, 32'(vsd), 32'h1);
        check({tag, ".full.pix_req"}, 32'(reqd), 32'h0);
        check({tag, ".full.frame_cnt"}, 32'(fcd), 32'h0);
    endtask

    initial begin
        int  fall1, fall2, hs_low, vs_low, fs_seen;
        logic prev_hs;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_small(0);
        check_full_reset("reset");

        // Free run past three frame wraps; stop inside the active area with frame_cnt = 3.
        rst_n = 1'b1;
        for (int n = 0; n <= 332; n++) begin
            if (n > 0) @(negedge clk);
            check_all_small(n);
        end

        // Asynchronous reset mid-frame: outputs clear without waiting for a clock.
        rst_n = 1'b0;
        #1;
        check_all_small(0);
        check_full_reset("midrst");
        repeat (2) @(negedge clk);
        check_all_small(0);

        // Restart from (0,0): small rasters re-checked, full raster line timing measured.
        rst_n   = 1'b1;
        fall1   = -1;
        fall2   = -1;
        hs_low  = 0;
        vs_low  = 0;
        fs_seen = 0;
        prev_hs = 1'b1;
        for (int n = 0; n <= D_FIRST_REQ + 645; n++) begin
            if (n > 0) @(negedge clk);
            if (n <= 200) check_all_small(n);
            if (!hsd && prev_hs) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!hsd && n < 800) hs_low++;
            if (!vsd) vs_low++;
            if (fsd) fs_seen++;
            prev_hs = hsd;
            if (n == D_FIRST_REQ - 1) check("full.req_before_first", 32'(reqd), 32'h0);
            if (n == D_FIRST_REQ) begin
                check("full.first_req", 32'(reqd), 32'h1);
                check("full.first_x", 32'(xd), 32'd0);
                check("full.first_y", 32'(yd), 32'd0);
            end
            if (n == D_FIRST_REQ + 639) begin
                check("full.last_x", 32'(xd), 32'd639);
                check("full.last_x_req", 32'(reqd), 32'h1);
            end
            if (n == D_FIRST_REQ + 640) check("full.req_after_line", 32'(reqd), 32'h0);
            if (n == D_FIRST_REQ + 1) check("full.rgb_before_first", 32'(rgbd), 32'h0);
            if (n == D_FIRST_REQ + 2) check("full.rgb_first", 32'(rgbd), 32'hFFFF);
            if (n == D_FIRST_REQ + 641) check("full.rgb_last", 32'(rgbd), 32'hFFFF);
            if (n == D_FIRST_REQ + 642) check("full.rgb_after_line", 32'(rgbd), 32'h0);
        end
        check("full.hsync_first_fall", 32'(fall1), 32'd2);
        check("full.hsync_period", 32'(fall2 - fall1), 32'd800);
        check("full.hsync_low", 32'(hs_low), 32'd96);
        check("full.vsync_low", 32'(vs_low), 32'd1600);
        check("full.no_frame_start", 32'(fs_seen), 32'd0);
        check("full.frame_cnt", 32'(fcd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
